// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
// Shared definitions for the SPI slave block.
//   DEFAULT_DATA_WIDTH : default number of bits per SPI frame
//   spi_state_e        : slave FSM states (IDLE = ss high, SELECTED = ss low)
// ---------------------------------------------------------------------------
package soc_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_SELECTED = 1'b1
   } spi_state_e;

endpackage : soc_pkg

// File: rtl/synchronizer.sv
// ---------------------------------------------------------------------------
// synchronizer
// Two-flop synchronizer that brings one asynchronous input into the clk domain.
//   clk       : system clock
//   reset     : synchronous active-low reset, forces both flops to RESET_VAL
//   d         : asynchronous input
//   q         : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module synchronizer #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule : synchronizer

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave, oversampled by clk (sclk<=clk/8).
//   clk, reset            : system clock, synchronous active-low reset
//   sclk, ss, mosi        : asynchronous SPI bus inputs (ss active-low)
//   miso, misoOe          : serial data to master and its output enable
//   txData/txValid/txReady: transmit word into a one-word holding register
//   rxData/rxValid/rxReady: received word with valid/ready handshake
//   rxOverrun, txUnderrun : sticky error flags, cleared by errClear
//   busy                  : synchronized ss is low
// ---------------------------------------------------------------------------
module spi_slave
   import soc_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] IDLE_DATA  = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  ss,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  misoOe,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic                  txValid,
   output logic                  txReady,
   output logic [DATA_WIDTH-1:0] rxData,
   output logic                  rxValid,
   input  logic                  rxReady,
   output logic                  rxOverrun,
   output logic                  txUnderrun,
   input  logic                  errClear,
   output logic                  busy
);

   localparam int               CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   // Synchronizer lanes: 0 = sclk, 1 = ss, 2 = mosi. Idle levels sclk=0, ss=1.
   localparam logic [2:0]       SYNC_RST = 3'b010;

   logic [2:0] async_in;
   logic [2:0] sync_out;
   logic       sclk_s, ss_s, mosi_s;

   assign async_in = {mosi, ss, sclk};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      synchronizer #(.RESET_VAL(SYNC_RST[gi])) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (async_in[gi]),
         .q     (sync_out[gi])
      );
   end

   assign sclk_s = sync_out[0];
   assign ss_s   = sync_out[1];
   assign mosi_s = sync_out[2];

   spi_state_e            state_q, state_d;
   logic                  sclk_prev_q;
   logic [1:0]            settle_q;
   logic                  armed_q, armed_d;
   logic [CNT_W-1:0]      bit_count_q, bit_count_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_overrun_q, rx_overrun_d;
   logic                  tx_underrun_q, tx_underrun_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_full_q, hold_full_d;
   logic                  last_bit_q, last_bit_d;
   logic                  pend_consume_q, pend_consume_d;
   logic                  pend_underrun_q, pend_underrun_d;
   logic                  sclk_rise, sclk_fall, tx_write;
   logic                  set_overrun, set_underrun;
   logic [DATA_WIDTH-1:0] rx_word;

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign tx_write  = txValid & ~hold_full_q;
   assign rx_word   = {rx_shift_q, mosi_s};

   always_comb begin
      state_d         = state_q;
      // Arm only once a genuinely high ss has passed through the synchronizer
      // after reset, so a master still holding ss low cannot start a frame.
      armed_d         = armed_q | (settle_q[1] & ss_s);
      bit_count_d     = bit_count_q;
      tx_shift_d      = tx_shift_q;
      rx_shift_d      = rx_shift_q;
      rx_data_d       = rx_data_q;
      rx_valid_d      = rx_valid_q;
      hold_data_d     = hold_data_q;
      hold_full_d     = hold_full_q;
      last_bit_d      = last_bit_q;
      pend_consume_d  = pend_consume_q;
      pend_underrun_d = pend_underrun_q;
      set_overrun     = 1'b0;
      set_underrun    = 1'b0;

      if (rx_valid_q && rxReady) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (armed_q && !ss_s) begin
               state_d         = ST_SELECTED;
               bit_count_d     = '0;
               last_bit_d      = 1'b0;
               pend_consume_d  = 1'b0;
               pend_underrun_d = 1'b0;
               if (hold_full_q) begin
                  tx_shift_d  = hold_data_q;
                  hold_full_d = 1'b0;
               end else begin
                  tx_shift_d   = IDLE_DATA;
                  set_underrun = 1'b1;
               end
            end
         end
         ST_SELECTED: begin
            if (ss_s) begin
               // Frame ended or aborted: partial word is dropped and any
               // speculative end-of-frame reload is forgotten.
               state_d         = ST_IDLE;
               bit_count_d     = '0;
               last_bit_d      = 1'b0;
               pend_consume_d  = 1'b0;
               pend_underrun_d = 1'b0;
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = rx_word[DATA_WIDTH-2:0];
                  // The first clock of a back-to-back frame proves the frame is
                  // real; only now commit the reload done at the previous fall.
                  if (bit_count_q == '0) begin
                     if (pend_consume_q) hold_full_d = 1'b0;
                     if (pend_underrun_q) set_underrun = 1'b1;
                     pend_consume_d  = 1'b0;
                     pend_underrun_d = 1'b0;
                  end
                  if (bit_count_q == LAST_BIT) begin
                     bit_count_d = '0;
                     last_bit_d  = 1'b1;
                     rx_data_d   = rx_word;
                     rx_valid_d  = 1'b1;
                     if (rx_valid_q && !rxReady) set_overrun = 1'b1;
                  end else begin
                     bit_count_d = bit_count_q + 1'b1;
                  end
               end
               if (sclk_fall) begin
                  if (last_bit_q) begin
                     last_bit_d = 1'b0;
                     if (hold_full_q) begin
                        tx_shift_d     = hold_data_q;
                        pend_consume_d = 1'b1;
                     end else begin
                        tx_shift_d      = IDLE_DATA;
                        pend_underrun_d = 1'b1;
                     end
                  end else begin
                     tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A write only happens while empty and a consume only while full, so a
      // write never collides with a consume of the same word.
      if (tx_write) begin
         hold_data_d = txData;
         hold_full_d = 1'b1;
      end

      rx_overrun_d  = set_overrun  ? 1'b1 : (errClear ? 1'b0 : rx_overrun_q);
      tx_underrun_d = set_underrun ? 1'b1 : (errClear ? 1'b0 : tx_underrun_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         sclk_prev_q     <= 1'b0;
         settle_q        <= 2'b00;
         armed_q         <= 1'b0;
         bit_count_q     <= '0;
         tx_shift_q      <= IDLE_DATA;
         rx_shift_q      <= '0;
         rx_data_q       <= '0;
         rx_valid_q      <= 1'b0;
         rx_overrun_q    <= 1'b0;
         tx_underrun_q   <= 1'b0;
         hold_data_q     <= '0;
         hold_full_q     <= 1'b0;
         last_bit_q      <= 1'b0;
         pend_consume_q  <= 1'b0;
         pend_underrun_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         sclk_prev_q     <= sclk_s;
         settle_q        <= {settle_q[0], 1'b1};
         armed_q         <= armed_d;
         bit_count_q     <= bit_count_d;
         tx_shift_q      <= tx_shift_d;
         rx_shift_q      <= rx_shift_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         rx_overrun_q    <= rx_overrun_d;
         tx_underrun_q   <= tx_underrun_d;
         hold_data_q     <= hold_data_d;
         hold_full_q     <= hold_full_d;
         last_bit_q      <= last_bit_d;
         pend_consume_q  <= pend_consume_d;
         pend_underrun_q <= pend_underrun_d;
      end
   end

   assign miso       = tx_shift_q[DATA_WIDTH-1];
   assign misoOe     = (state_q == ST_SELECTED);
   assign txReady    = ~hold_full_q;
   assign rxData     = rx_data_q;
   assign rxValid    = rx_valid_q;
   assign rxOverrun  = rx_overrun_q;
   assign txUnderrun = tx_underrun_q;
   assign busy       = ~ss_s;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a behavioural mode-0 master drives the bus
// with sclk = clk/10 and every result is compared to hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_slave;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         sclk = 1'b0;
   logic         ss = 1'b1;
   logic         mosi = 1'b0;
   logic         miso, misoOe;
   logic [W-1:0] txData = '0;
   logic         txValid = 1'b0;
   logic         txReady;
   logic [W-1:0] rxData;
   logic         rxValid;
   logic         rxReady = 1'b0;
   logic         rxOverrun, txUnderrun;
   logic         errClear = 1'b0;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   int           rx_count = 0;
   logic [W-1:0] rx_log [0:63];

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(W), .IDLE_DATA(8'h00)) dut (
      .clk        (clk),
      .reset      (reset),
      .sclk       (sclk),
      .ss         (ss),
      .mosi       (mosi),
      .miso       (miso),
      .misoOe     (misoOe),
      .txData     (txData),
      .txValid    (txValid),
      .txReady    (txReady),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .rxReady    (rxReady),
      .rxOverrun  (rxOverrun),
      .txUnderrun (txUnderrun),
      .errClear   (errClear),
      .busy       (busy)
   );

   // Log every completed rx handshake.
   always @(posedge clk) begin
      if (reset && rxValid && rxReady) begin
         rx_log[rx_count[5:0]] <= rxData;
         rx_count              <= rx_count + 1;
      end
   end

   // ---------------- bus / handshake helpers (no checking) -----------------
   task automatic spi_bits(input logic [W-1:0] out_word, input int nbits,
                           output logic [W-1:0] in_word);
      in_word = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = out_word[W-1-i];
         #50;
         sclk = 1'b1;
         in_word[W-1-i] = miso;
         #50;
         sclk = 1'b0;
      end
   endtask

   task automatic select_bus();
      @(negedge clk);
      ss = 1'b0;
      #80;
   endtask

   task automatic deselect_bus();
      #20;
      ss = 1'b1;
      #80;
   endtask

   task automatic queue_tx(input logic [W-1:0] w);
      @(negedge clk);
      txData  = w;
      txValid = 1'b1;
      @(negedge clk);
      txValid = 1'b0;
   endtask

   task automatic pop_rx();
      @(negedge clk);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      errClear = 1'b1;
      @(negedge clk);
      errClear = 1'b0;
   endtask

   task automatic wait_rx(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rxValid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------ tests ----------------------------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({misoOe, busy, txReady, rxValid, rxOverrun, txUnderrun, miso} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0010000", {misoOe, busy, txReady, rxValid, rxOverrun, txUnderrun, miso});
      end
      n_checks++;
      if (rxData !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rxdata: got %h expected 00", rxData);
      end
      reset = 1'b1;
      repeat (6) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [W-1:0] rd;
      bit ok;
      queue_tx(8'hA5);
      select_bus();
      n_checks++;
      if (misoOe !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_select: got oe=%b busy=%b expected 1 1", misoOe, busy);
      end
      spi_bits(8'h3C, 8, rd);
      $display("basic frame: mosi=3c miso=%h", rd);
      n_checks++;
      if (rd !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_miso: got %h expected a5", rd);
      end
      wait_rx(ok);
      n_checks++;
      if (!ok || rxData !== 8'h3C) begin
         n_fail++;
         $display("FAIL basic_rx: got valid=%b data=%h expected 1 3c", ok, rxData);
      end
      deselect_bus();
      n_checks++;
      if (misoOe !== 1'b0 || txUnderrun !== 1'b0 || rxOverrun !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_after: got oe=%b ur=%b or=%b expected 0 0 0", misoOe, txUnderrun, rxOverrun);
      end
      pop_rx();
      n_checks++;
      if (rxValid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pop: got rxValid=%b expected 0", rxValid);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] tw [0:2];
      logic [W-1:0] mw [0:2];
      logic [W-1:0] rd;
      int base;
      tw[0] = 8'h01; tw[1] = 8'h02; tw[2] = 8'h03;
      mw[0] = 8'h5A; mw[1] = 8'hC3; mw[2] = 8'h96;
      base = rx_count;
      rxReady = 1'b1;
      queue_tx(tw[0]);
      select_bus();
      for (int k = 0; k < 3; k++) begin
         fork
            spi_bits(mw[k], 8, rd);
            begin
               if (k < 2) begin
                  #200;
                  queue_tx(tw[k+1]);
               end
            end
         join
         $display("b2b frame %0d: mosi=%h miso=%h", k, mw[k], rd);
         n_checks++;
         if (rd !== tw[k]) begin
            n_fail++;
            $display("FAIL b2b_miso%0d: got %h expected %h", k, rd, tw[k]);
         end
      end
      deselect_bus();
      repeat (4) @(negedge clk);
      rxReady = 1'b0;
      n_checks++;
      if (rx_count - base !== 3) begin
         n_fail++;
         $display("FAIL b2b_rxcount: got %0d expected 3", rx_count - base);
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rx_log[6'(base + k)] !== mw[k]) begin
            n_fail++;
            $display("FAIL b2b_rx%0d: got %h expected %h", k, rx_log[6'(base + k)], mw[k]);
         end
      end
      n_checks++;
      if (txUnderrun !== 1'b0 || rxOverrun !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_errors: got ur=%b or=%b expected 0 0", txUnderrun, rxOverrun);
      end
   endtask

   task automatic test_underrun();
      logic [W-1:0] rd;
      select_bus();
      spi_bits(8'h77, 8, rd);
      $display("underrun frame: mosi=77 miso=%h", rd);
      n_checks++;
      if (rd !== 8'h00) begin
         n_fail++;
         $display("FAIL underrun_miso: got %h expected 00", rd);
      end
      deselect_bus();
      n_checks++;
      if (txUnderrun !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_flag: got %b expected 1", txUnderrun);
      end
      pulse_clear();
      pop_rx();
      n_checks++;
      if (txUnderrun !== 1'b0 || rxValid !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_clear: got ur=%b rxValid=%b expected 0 0", txUnderrun, rxValid);
      end
   endtask

   task automatic test_overrun();
      logic [W-1:0] rd;
      rxReady = 1'b0;
      select_bus();
      spi_bits(8'h11, 8, rd);
      repeat (4) @(negedge clk);
      n_checks++;
      if (rxValid !== 1'b1 || rxOverrun !== 1'b0 || rxData !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_first: got v=%b or=%b d=%h expected 1 0 11", rxValid, rxOverrun, rxData);
      end
      spi_bits(8'h22, 8, rd);
      deselect_bus();
      $display("overrun frames: mosi=11,22 rxData=%h", rxData);
      n_checks++;
      if (rxValid !== 1'b1 || rxOverrun !== 1'b1 || rxData !== 8'h22) begin
         n_fail++;
         $display("FAIL overrun_second: got v=%b or=%b d=%h expected 1 1 22", rxValid, rxOverrun, rxData);
      end
      pulse_clear();
      pop_rx();
      n_checks++;
      if (rxOverrun !== 1'b0 || txUnderrun !== 1'b0 || rxValid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got or=%b ur=%b v=%b expected 0 0 0", rxOverrun, txUnderrun, rxValid);
      end
   endtask

   task automatic test_abort();
      logic [W-1:0] rd;
      bit ok;
      select_bus();
      fork
         spi_bits(8'hF0, 4, rd);
         begin
            #150;
            queue_tx(8'h6B);
         end
      join
      deselect_bus();
      repeat (4) @(negedge clk);
      $display("abort: 4 bits sent, txReady=%b rxValid=%b", txReady, rxValid);
      n_checks++;
      if (rxValid !== 1'b0 || dut.bit_count_q !== 3'd0) begin
         n_fail++;
         $display("FAIL abort_rx: got v=%b cnt=%0d expected 0 0", rxValid, dut.bit_count_q);
      end
      n_checks++;
      if (txReady !== 1'b0 || misoOe !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_tx: got txReady=%b oe=%b expected 0 0", txReady, misoOe);
      end
      pulse_clear();
      select_bus();
      spi_bits(8'h99, 8, rd);
      wait_rx(ok);
      deselect_bus();
      $display("post-abort frame: mosi=99 miso=%h rxData=%h", rd, rxData);
      n_checks++;
      if (rd !== 8'h6B || !ok || rxData !== 8'h99) begin
         n_fail++;
         $display("FAIL abort_next: got miso=%h v=%b d=%h expected 6b 1 99", rd, ok, rxData);
      end
      pop_rx();
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] rd;
      bit ok;
      queue_tx(8'h3E);
      select_bus();
      spi_bits(8'hAA, 4, rd);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({misoOe, busy, txReady, rxValid, rxOverrun, txUnderrun, miso} !== 7'b0010000
          || rxData !== 8'h00 || dut.bit_count_q !== 3'd0) begin
         n_fail++;
         $display("FAIL rstmid_values: got flags=%b d=%h cnt=%0d expected 0010000 00 0",
                  {misoOe, busy, txReady, rxValid, rxOverrun, txUnderrun, miso}, rxData, dut.bit_count_q);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++;
      if (misoOe !== 1'b0 || rxValid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_noselect: got oe=%b v=%b expected 0 0", misoOe, rxValid);
      end
      deselect_bus();
      queue_tx(8'hE7);
      select_bus();
      spi_bits(8'h81, 8, rd);
      wait_rx(ok);
      deselect_bus();
      $display("post-reset frame: mosi=81 miso=%h rxData=%h", rd, rxData);
      n_checks++;
      if (rd !== 8'hE7 || !ok || rxData !== 8'h81) begin
         n_fail++;
         $display("FAIL rstmid_frame: got miso=%h v=%b d=%h expected e7 1 81", rd, ok, rxData);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spi_slave
